spi_master_seq: RTL
===================

# spi_master_seq

- Master-side transaction sequencer for the SPI RAM wrapper.
- Accepts single-word write or read requests from a host over a valid/ready handshake.
- Converts each request into the wrapper's mandatory two-frame command pair: write-address (00) then write-data (01), or read-address (10) then read-data (11). It drives SS_n/MOSI and captures MISO.
- Pairs are issued atomically, so the wrapper never sees an orphaned address frame.

## Interface

Parameters:
- GAP_CYC, 1, SS_n-high cycles between the two frames of a pair (≥1)
- RD_LAT, 2, cycles from last MOSI payload bit of read-data frame to first MISO bit (≥1)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  host request present
- req_ready  out  1  block idle and able to accept
- req_rd  in  1  1 = read, 0 = write
- req_addr  in  8  RAM address
- req_wdata  in  8  write data (ignored for reads)
- resp_valid  out  1  one-cycle pulse: transaction complete
- resp_rdata  out  8  read data, valid with resp_valid (holds last value otherwise)
- busy  out  1  transaction in progress
- SS_n  out  1  slave select, active low, registered
- MOSI  out  1  serial data to wrapper, registered
- MISO  in  1  serial data from wrapper, sampled on posedge

## Operation

- States: IDLE, SEL, SHIFT, GAP, RD_WAIT, RD_RX, DONE.
- Frames:
  - First frame = {cmd, req_addr}: cmd 00 for write, 10 for read.
  - Second frame = {cmd, payload}: cmd 01 with req_wdata for write, cmd 11 with 8'h00 for read.
- Payload latch: frames are latched at acceptance. Host inputs are don't-care afterwards.
- IDLE:
  - req_ready = 1 (forced 0 while rst_n low).
  - Acceptance happens when req_valid && req_ready; the next state is SEL.
- SEL (1 cycle):
  - SS_n = 0; MOSI = frame[9] (the wrapper's read/write select bit).
  - Then SHIFT.
- SHIFT (10 cycles):
  - SS_n = 0; MOSI = frame[9] down to frame[0], MSB first. A 4-bit counter counts 0..9.
  - Exit after first frame → GAP.
  - Exit after write-data frame → DONE.
  - Exit after read-data frame → RD_WAIT.
- GAP (GAP_CYC cycles): SS_n = 1, MOSI = 0, then SEL for the second frame.
- RD_WAIT (RD_LAT cycles): SS_n = 0, MOSI = 0.
- RD_RX (8 cycles):
  - SS_n = 0.
  - MISO shifted into the rdata register, MSB first.
- DONE (1 cycle):
  - SS_n = 1; resp_valid = 1; resp_rdata updated for reads only.
  - Then IDLE.
- busy = (state != IDLE).
- Requests while busy: req_valid is ignored; req_ready = 0.
- Response backpressure: none. resp_valid is a pulse and the host must capture it.
- Back-to-back requests: a request accepted in the DONE→IDLE cycle starts its SEL one cycle later. SS_n is therefore high ≥2 cycles between transactions.

## Timing

- Reset values (asynchronous, immediate): SS_n=1, MOSI=0, resp_valid=0, resp_rdata=8'h00, busy=0, req_ready=0 while reset asserted, state=IDLE.
- Reset mid-transaction: SS_n rises asynchronously and the transaction is dropped. No resp_valid is issued. The wrapper sees an aborted frame.
- Write with request accepted at edge T (defaults):
  - Frame 1: SS_n low T+1..T+11.
  - Gap: SS_n high T+12.
  - Frame 2: SS_n low T+13..T+23.
  - resp_valid at T+24.
  - Latency = 24 cycles.
- Read with request accepted at edge T (defaults):
  - Frames as for write through T+23.
  - RD_WAIT T+24..T+25.
  - MISO sampled at edges T+26..T+33.
  - DONE at T+34: SS_n high, resp_valid, rdata.
  - Latency = 26 + GAP_CYC − 1 + RD_LAT + 8 − 2 in general form. Defaults give 34.
- Counter: 4-bit, saturating never reached; it reloads on every state entry.

## Structure

- Shared package (WRAPPER_shared_pkg) holds:
  - cmd_e: WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11
  - state enum
  - frame width constant FRAME_W=10 and DATA_W=8
- One sub-module: spi_frame_shifter.
  - 10-bit parallel-load MSB-first shift register with bit counter and done flag.
  - Reused for the MOSI transmit path.
  - The MISO receive is an 8-bit shift in the top level.

## Test plan

- Write addr=8'h3C, wdata=8'hA5 → MOSI streams 0,00_0011_1100, gap, 0,01_1010_0101. resp_valid at T+24. Wrapper RAM[8'h3C]=8'hA5.
- Read addr=8'h3C after above → MOSI frames 1,10_0011_1100 and 1,11_0000_0000. MISO captured. resp_rdata=8'hA5 at T+34.
- req_valid held high across two requests (write then read) → second accepted only when req_ready=1. SS_n high ≥2 cycles between them. No frame overlap.
- rst_n low at T+15 of a write → SS_n=1 in the same cycle, no resp_valid, req_ready=0 until rst_n release, then 1.
- GAP_CYC=3, RD_LAT=1 build, read of 8'h00 preloaded with 8'hFF → SS_n high exactly 3 cycles between frames. resp_rdata=8'hFF at T+35.
- Protocol check: every 00/10 frame is followed by a 01/11 frame before any other SEL.

Source files
------------

// File: rtl/spi_master_seq_pkg.sv
// Shared definitions for the SPI RAM wrapper master sequencer:
// command codes, sequencer states, frame geometry and a frame builder.
package spi_master_seq_pkg;

   localparam int FRAME_W = 10;
   localparam int DATA_W  = 8;
   localparam int CNT_W   = 4;

   // Two-bit command prefix understood by the wrapper.
   typedef enum logic [1:0] {
      WR_ADDR = 2'b00,
      WR_DATA = 2'b01,
      RD_ADDR = 2'b10,
      RD_DATA = 2'b11
   } cmd_e;

   // Sequencer states.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SEL     = 3'd1,
      ST_SHIFT   = 3'd2,
      ST_GAP     = 3'd3,
      ST_RD_WAIT = 3'd4,
      ST_RD_RX   = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   // A frame is the command prefix followed by the 8-bit payload.
   function automatic logic [FRAME_W-1:0] make_frame(input cmd_e cmd,
                                                     input logic [DATA_W-1:0] payload);
      return {cmd, payload};
   endfunction

endpackage

// File: rtl/spi_master_seq_frame_shifter.sv
// Parallel-load, MSB-first frame shift register for the MOSI path.
// o_msb is the bit currently presented; o_done flags the shift of the last bit.
module spi_frame_shifter
   import spi_master_seq_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_load,
   input  logic [FRAME_W-1:0] i_data,
   input  logic               i_shift,
   output logic               o_msb,
   output logic               o_done
);

   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

   logic [FRAME_W-1:0] r_sh;
   logic [CNT_W-1:0]   r_cnt;

   // Load a new frame, or move the next bit up to the MSB and count it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh  <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_sh  <= i_data;
         r_cnt <= '0;
      end else if (i_shift) begin
         r_sh  <= {r_sh[FRAME_W-2:0], 1'b0};
         r_cnt <= r_cnt + 4'd1;
      end else begin
         r_sh  <= r_sh;
         r_cnt <= r_cnt;
      end
   end

   assign o_msb  = r_sh[FRAME_W-1];
   assign o_done = i_shift && (r_cnt == LAST_BIT);

endmodule

// File: rtl/spi_master_seq.sv
// Master-side sequencer for the SPI RAM wrapper. Each accepted host request
// becomes an atomic address-frame / data-frame pair on SS_n/MOSI; reads then
// wait RD_LAT cycles and shift 8 bits of MISO in, MSB first.
// All pin-level outputs are registered from the current state, so they trail
// the state register by one cycle.
module spi_master_seq
   import spi_master_seq_pkg::*;
#(
   parameter int GAP_CYC = 1,
   parameter int RD_LAT  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_rd,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              busy,
   output logic              SS_n,
   output logic              MOSI,
   input  logic              MISO
);

   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(DATA_W - 1);

   state_e              r_state;
   state_e              w_next_state;
   logic [CNT_W-1:0]    r_cnt;
   logic                r_second;
   logic                r_is_rd;
   logic [FRAME_W-1:0]  r_frame2;
   logic [DATA_W-1:0]   r_rx;
   logic [DATA_W-1:0]   r_rdata;
   logic                r_ss_n;
   logic                r_mosi;
   logic                r_resp_valid;
   logic                r_req_ready;
   logic                r_busy;

   logic                w_accept;
   logic                w_load;
   logic [FRAME_W-1:0]  w_load_data;
   logic                w_shift;
   logic                w_msb;
   logic                w_done;
   logic                w_ss_n_d;
   logic                w_mosi_d;

   assign w_accept = req_valid && r_req_ready && (r_state == ST_IDLE);

   spi_frame_shifter u_shifter (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load),
      .i_data  (w_load_data),
      .i_shift (w_shift),
      .o_msb   (w_msb),
      .o_done  (w_done)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; the second frame always follows the first via GAP.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_next_state = ST_SEL;
            else          w_next_state = ST_IDLE;
         end
         ST_SEL: begin
            w_next_state = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (!w_done)       w_next_state = ST_SHIFT;
            else if (!r_second) w_next_state = ST_GAP;
            else if (r_is_rd)   w_next_state = ST_RD_WAIT;
            else                w_next_state = ST_DONE;
         end
         ST_GAP: begin
            if (r_cnt == GAP_LAST) w_next_state = ST_SEL;
            else                   w_next_state = ST_GAP;
         end
         ST_RD_WAIT: begin
            if (r_cnt == WAIT_LAST) w_next_state = ST_RD_RX;
            else                    w_next_state = ST_RD_WAIT;
         end
         ST_RD_RX: begin
            if (r_cnt == RX_LAST) w_next_state = ST_DONE;
            else                  w_next_state = ST_RD_RX;
         end
         ST_DONE: begin
            w_next_state = ST_IDLE;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // Shifter control: the address frame is built straight from the host
   // inputs on acceptance, the data frame comes from the latched copy.
   always_comb begin
      w_load      = 1'b0;
      w_load_data = r_frame2;
      if (w_accept) begin
         w_load      = 1'b1;
         w_load_data = make_frame(req_rd ? RD_ADDR : WR_ADDR, req_addr);
      end else if ((r_state == ST_GAP) && (w_next_state == ST_SEL)) begin
         w_load      = 1'b1;
         w_load_data = r_frame2;
      end else begin
         w_load      = 1'b0;
         w_load_data = r_frame2;
      end
      w_shift = (r_state == ST_SHIFT);
   end

   // Per-state cycle counter, restarted from zero on every state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (w_next_state != r_state) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

   // Latch the request at acceptance and track which frame of the pair is active.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_is_rd  <= 1'b0;
         r_frame2 <= '0;
         r_second <= 1'b0;
      end else if (w_accept) begin
         r_is_rd  <= req_rd;
         r_frame2 <= make_frame(req_rd ? RD_DATA : WR_DATA,
                                req_rd ? 8'h00 : req_wdata);
         r_second <= 1'b0;
      end else if ((r_state == ST_GAP) && (w_next_state == ST_SEL)) begin
         r_second <= 1'b1;
      end else begin
         r_second <= r_second;
      end
   end

   // Read-data capture: MISO shifted in MSB first while in RD_RX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx <= '0;
      end else if (r_state == ST_RD_RX) begin
         r_rx <= {r_rx[DATA_W-2:0], MISO};
      end else begin
         r_rx <= r_rx;
      end
   end

   // Pin-level values for the current state, registered below.
   always_comb begin
      w_ss_n_d = 1'b1;
      w_mosi_d = 1'b0;
      case (r_state)
         ST_SEL, ST_SHIFT: begin
            w_ss_n_d = 1'b0;
            w_mosi_d = w_msb;
         end
         ST_RD_WAIT, ST_RD_RX: begin
            w_ss_n_d = 1'b0;
            w_mosi_d = 1'b0;
         end
         ST_IDLE, ST_GAP, ST_DONE: begin
            w_ss_n_d = 1'b1;
            w_mosi_d = 1'b0;
         end
         default: begin
            w_ss_n_d = 1'b1;
            w_mosi_d = 1'b0;
         end
      endcase
   end

   // Registered outputs; reset releases the bus (SS_n high) immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ss_n       <= 1'b1;
         r_mosi       <= 1'b0;
         r_resp_valid <= 1'b0;
         r_rdata      <= '0;
         r_req_ready  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_ss_n       <= w_ss_n_d;
         r_mosi       <= w_mosi_d;
         r_resp_valid <= (r_state == ST_DONE);
         r_rdata      <= ((r_state == ST_DONE) && r_is_rd) ? r_rx : r_rdata;
         r_req_ready  <= (w_next_state == ST_IDLE);
         r_busy       <= (w_next_state != ST_IDLE);
      end
   end

   assign SS_n       = r_ss_n;
   assign MOSI       = r_mosi;
   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_rdata;
   assign req_ready  = r_req_ready;
   assign busy       = r_busy;

endmodule
